argmax_stream: RTL and testbench
================================

Name: argmax_stream

Overview:
- Sequential, parametrised successor to the combinational 10-way max block.
- Consumes one sign-magnitude score per cycle over a valid/ready stream and tracks the running maximum and its position.
- After the frame ends, presents the winning value and its class index on a held valid/ready output.
- Sits between the output-layer MAC/activation stage and the digit display/UART result path. Supports any class count and data width.

Parameters:
- DATA_W, 16: score width; MSB is sign, DATA_W-1 LSBs are magnitude.
- N_CLASSES, 10: maximum elements per frame (2..256).
- REVERSE_IDX, 1: 1 makes out_index = N_CLASSES-1-pos; 0 makes out_index = pos. pos is the 0-based arrival order.
- IDX_W (localparam): $clog2(N_CLASSES), minimum 1.
- CNT_W (localparam): $clog2(N_CLASSES+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  score beat valid
- in_ready  out  1  block accepts beat
- in_data  in  DATA_W  sign-magnitude score
- in_last  in  1  final beat of frame
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- out_max  out  DATA_W  winning score
- out_index  out  IDX_W  winning class index
- out_count  out  CNT_W  beats in the frame
- out_sat  out  1  winner is the saturation marker
- out_short  out  1  frame ended via in_last before N_CLASSES beats

Behaviour:
- Reset values: all outputs 0 and in_ready=0 while rst is high; state=IDLE. in_ready rises the first clock after rst falls.
- Saturation marker SAT = {1'b1, (DATA_W-1){0}}, i.e. negative zero. It beats every other value. Once it is the running max, the max and index lock for the rest of the frame. A later SAT does not replace an earlier one.
- Compare rule (cand vs cur, neither SAT):
  - Signs differ: the positive value wins.
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - Equal values: cur is kept, so the earliest element wins ties.
- States:
  - IDLE: in_ready=1. The first handshake loads cur=in_data and pos=0, sets count=1, and moves to ACCUM. If that beat also has in_last, or N_CLASSES==1, go straight to DONE.
  - ACCUM: in_ready=1. Each handshake applies the compare, increments the position, and increments count. The frame ends on a beat with in_last=1 or on the beat that makes count==N_CLASSES, whichever comes first; then go to DONE.
  - DONE: in_ready=0 and out_valid=1. Outputs are registered and stable. On out_ready=1, go to IDLE next cycle; there is no same-cycle bypass to a new frame.
- Latency: out_valid rises on the clock edge after the final beat's handshake, i.e. 1 cycle.
- Boundaries:
  - in_valid=0 mid-frame: state and count hold indefinitely.
  - Beats beyond N_CLASSES without in_last: the frame is forced closed at N_CLASSES and out_short=0. The next beat starts a new frame.
  - in_last on beat N_CLASSES: normal end, out_short=0.
  - in_last before beat N_CLASSES: out_short=1.
  - rst asserted mid-frame or in DONE: the frame is discarded and all outputs return to reset values immediately.
- Width: count is compared at CNT_W bits and out_index at IDX_W bits; there is no wrap, because the frame closes at N_CLASSES.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- When defined:
  - Adds ports out_max2 (DATA_W) and out_index2 (IDX_W), holding the runner-up under the same compare rule.
  - A displaced max becomes the runner-up. A candidate that loses to max but beats the runner-up replaces the runner-up.
  - With count==1, the runner-up outputs are 0.
  - While max is locked on SAT, a later SAT becomes the runner-up.
- When undefined: no extra ports or registers, and behaviour is exactly as above.

Test Plan:
- Reset then 10 beats [0x0003,0x0010,0x8005,0x0010,0x0001,0x0002,0x8001,0x0007,0x0000,0x0004], in_last on beat 10, REVERSE_IDX=1 -> out_max=0x0010, out_index=8 (pos1), out_count=10, out_short=0, out_sat=0; out_valid on the next cycle.
- All negative [0x8009,0x8003,0x8007,…] -> out_max=0x8003 (smallest magnitude), correct reversed index.
- SAT at pos 4 and pos 7, larger positives elsewhere -> out_max=0x8000, out_sat=1, out_index=5.
- in_last on beat 6 -> out_count=6, out_short=1. 13 beats without in_last -> first result after beat 10 with count 10; beats 11–13 begin the next frame.
- Random in_valid gaps plus out_ready held low for 5 cycles -> outputs stable, in_ready=0 throughout DONE, no beats lost; rst asserted at beat 4 -> out_valid=0 and the next frame's result is independent.
- ARGMAX_TOP2_EN with [0x0005,0x0009,0x0007] and N=3 -> max 0x0009 at pos1, runner-up 0x0007 at pos2.

Source files
------------

// File: rtl/argmax_stream.sv
// -----------------------------------------------------------------------------
// argmax_stream
//
// Streaming arg-max over one frame of sign-magnitude scores. One score per
// cycle arrives on a valid/ready stream. The block tracks the running maximum
// and its class index, then presents the winner on a held valid/ready output.
// It sits between the output-layer MAC/activation stage and the digit display /
// UART result path.
//
// Score format: the MSB is the sign and the DATA_W-1 LSBs are the magnitude.
// Negative zero ({1'b1, 0...}) is the saturation marker SAT. SAT beats every
// other value, and once SAT holds the running maximum that maximum is locked
// for the rest of the frame.
//
// Optional feature (compile-time macro ARGMAX_TOP2_EN):
//   When defined, out_max2/out_index2 carry the runner-up under the same
//   compare rule. When undefined, those ports and registers do not exist.
//
// Parameters:
//   DATA_W       score width, sign + magnitude
//   N_CLASSES    maximum beats per frame (2..256); the frame closes there
//   REVERSE_IDX  1: out_index = N_CLASSES-1-pos, 0: out_index = pos
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    score beat valid
//   in_ready    block accepts a beat (low in DONE and while in reset)
//   in_data     sign-magnitude score
//   in_last     final beat of frame
//   out_valid   result valid, held until out_ready
//   out_ready   downstream accepts result
//   out_max     winning score
//   out_index   winning class index
//   out_count   number of beats in the frame
//   out_sat     winner is the saturation marker
//   out_short   frame ended by in_last before N_CLASSES beats
//   out_max2    runner-up score          (ARGMAX_TOP2_EN only)
//   out_index2  runner-up class index    (ARGMAX_TOP2_EN only)
// -----------------------------------------------------------------------------
module argmax_stream #(
    parameter int DATA_W      = 16,
    parameter int N_CLASSES   = 10,
    parameter int REVERSE_IDX = 1,
    localparam int IDX_W      = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1,
    localparam int CNT_W      = $clog2(N_CLASSES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_index,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_short
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [DATA_W-1:0] out_max2,
    output logic [IDX_W-1:0]  out_index2
`endif
);

    localparam logic [DATA_W-1:0] SAT       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_CLASSES);
    localparam logic [CNT_W-1:0]  LAST_POS  = CNT_W'(N_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // True when cand strictly beats cur. Equal values return 0, so the
    // earliest element wins ties. A SAT already held in cur is never displaced.
    function automatic logic beats(input logic [DATA_W-1:0] cand,
                                   input logic [DATA_W-1:0] cur);
        logic              cand_neg;
        logic              cur_neg;
        logic [DATA_W-2:0] cand_mag;
        logic [DATA_W-2:0] cur_mag;
        cand_neg = cand[DATA_W-1];
        cur_neg  = cur[DATA_W-1];
        cand_mag = cand[DATA_W-2:0];
        cur_mag  = cur[DATA_W-2:0];
        if (cur == SAT) begin
            beats = 1'b0;
        end else if (cand == SAT) begin
            beats = 1'b1;
        end else if (cand_neg != cur_neg) begin
            beats = cur_neg;                // the positive value wins
        end else if (!cand_neg) begin
            beats = (cand_mag > cur_mag);
        end else begin
            beats = (cand_mag < cur_mag);   // closer to zero is larger
        end
    endfunction

    // Arrival position to reported class index.
    function automatic logic [IDX_W-1:0] map_idx(input logic [CNT_W-1:0] pos);
        logic [CNT_W-1:0] idx_wide;
        if (REVERSE_IDX != 0) begin
            idx_wide = LAST_POS - pos;
        end else begin
            idx_wide = pos;
        end
        map_idx = idx_wide[IDX_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic                ready_q;
    logic                valid_q;

    logic [DATA_W-1:0]   max_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    count_q;

    logic [DATA_W-1:0]   res_max_q;
    logic [IDX_W-1:0]    res_idx_q;
    logic [CNT_W-1:0]    res_count_q;
    logic                res_sat_q;
    logic                res_short_q;

    // -------------------------------------------------------------------------
    // Beat-level combinational signals
    // -------------------------------------------------------------------------
    logic                fire;
    logic [CNT_W-1:0]    pos;
    logic [CNT_W-1:0]    count_d;
    logic                frame_end;
    logic [DATA_W-1:0]   max_d;
    logic [IDX_W-1:0]    idx_d;

    // in_ready is a register so that it stays low throughout reset and rises
    // on the first clock after reset is released.
    assign fire      = in_valid && ready_q;
    assign pos       = (state_q == IDLE) ? '0 : count_q;
    assign count_d   = pos + CNT_W'(1);
    // The frame also closes at N_CLASSES, so count never wraps.
    assign frame_end = fire && (in_last || (count_d == CNT_FULL));

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if ((state_q == IDLE) || beats(in_data, max_q)) begin
            max_d = in_data;
            idx_d = map_idx(pos);
        end
    end

`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0]   max2_q;
    logic [IDX_W-1:0]    idx2_q;
    logic                has2_q;
    logic [DATA_W-1:0]   max2_d;
    logic [IDX_W-1:0]    idx2_d;
    logic                has2_d;
    logic [DATA_W-1:0]   res_max2_q;
    logic [IDX_W-1:0]    res_idx2_q;

    // Runner-up update. A displaced max moves down. A candidate that loses to
    // max but beats the runner-up takes its place. While max is locked on SAT,
    // beats() still lets a later SAT displace a non-SAT runner-up.
    always_comb begin
        max2_d = max2_q;
        idx2_d = idx2_q;
        has2_d = has2_q;
        if (state_q == IDLE) begin
            max2_d = '0;
            idx2_d = '0;
            has2_d = 1'b0;
        end else if (beats(in_data, max_q)) begin
            max2_d = max_q;
            idx2_d = idx_q;
            has2_d = 1'b1;
        end else if (!has2_q || beats(in_data, max2_q)) begin
            max2_d = in_data;
            idx2_d = map_idx(pos);
            has2_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max2_q     <= '0;
            idx2_q     <= '0;
            has2_q     <= 1'b0;
            res_max2_q <= '0;
            res_idx2_q <= '0;
        end else begin
            if (fire) begin
                max2_q <= max2_d;
                idx2_q <= idx2_d;
                has2_q <= has2_d;
            end
            if (frame_end) begin
                res_max2_q <= max2_d;
                res_idx2_q <= idx2_d;
            end
        end
    end

    assign out_max2   = res_max2_q;
    assign out_index2 = res_idx2_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = frame_end ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (frame_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // No same-cycle bypass: a new frame starts from IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != DONE);
            valid_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else if (fire) begin
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Result registers are loaded once, on the closing beat, so the outputs
    // stay stable for as long as DONE is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_max_q   <= '0;
            res_idx_q   <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
            res_short_q <= 1'b0;
        end else if (frame_end) begin
            res_max_q   <= max_d;
            res_idx_q   <= idx_d;
            res_count_q <= count_d;
            res_sat_q   <= (max_d == SAT);
            res_short_q <= in_last && (count_d != CNT_FULL);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_max   = res_max_q;
    assign out_index = res_idx_q;
    assign out_count = res_count_q;
    assign out_sat   = res_sat_q;
    assign out_short = res_short_q;

endmodule

// File: tb/tb_argmax_stream.sv
// -----------------------------------------------------------------------------
// tb_argmax_stream
//
// Directed bench for argmax_stream with DATA_W=16, N_CLASSES=10,
// REVERSE_IDX=1. Expected values are hand-computed per frame.
// -----------------------------------------------------------------------------
module tb_argmax_stream;

    localparam int DATA_W    = 16;
    localparam int N_CLASSES = 10;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_index;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic              out_short;
`ifdef ARGMAX_TOP2_EN
    logic [DATA_W-1:0] out_max2;
    logic [IDX_W-1:0]  out_index2;
`endif

    int checks = 0;
    int errors = 0;

    argmax_stream #(
        .DATA_W     (DATA_W),
        .N_CLASSES  (N_CLASSES),
        .REVERSE_IDX(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_index (out_index),
        .out_count (out_count),
        .out_sat   (out_sat),
        .out_short (out_short)
`ifdef ARGMAX_TOP2_EN
        ,
        .out_max2  (out_max2),
        .out_index2(out_index2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, wait (bounded) for in_ready, handshake on the next
    // edge, and return 1 time unit after that edge.
    task automatic send(input logic [DATA_W-1:0] data, input logic last, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_before_beat", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid_wait", out_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic [DATA_W-1:0] mx,
                                input logic [IDX_W-1:0] idx, input logic [CNT_W-1:0] cnt,
                                input logic sat, input logic shrt);
        check({tag, "_max"},   out_max,   mx);
        check({tag, "_index"}, out_index, idx);
        check({tag, "_count"}, out_count, cnt);
        check({tag, "_sat"},   out_sat,   sat);
        check({tag, "_short"}, out_short, shrt);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_ack", out_valid, 0);
    endtask

    logic [DATA_W-1:0] v [0:9];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max",   out_max,   0);
        check("rst_out_index", out_index, 0);
        check("rst_out_count", out_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Frame 1: mixed signs, tie on 0x0010 (pos1 and pos3) keeps pos1
        v = '{16'h0003, 16'h0010, 16'h8005, 16'h0010, 16'h0001,
              16'h0002, 16'h8001, 16'h0007, 16'h0000, 16'h0004};
        for (int i = 0; i < 10; i++) begin
            send(v[i], (i == 9), 0);
        end
        check("f1_latency_valid", out_valid, 1);
        check("f1_in_ready_done", in_ready, 0);
        check_result("f1", 16'h0010, 4'd8, 4'd10, 1'b0, 1'b0);
`ifdef ARGMAX_TOP2_EN
        check("f1_max2",   out_max2,   16'h0010);
        check("f1_index2", out_index2, 4'd6);
`endif
        ack();

        // Frame 2: all negative, in_last on beat 6
        v = '{16'h8009, 16'h8003, 16'h8007, 16'h8004, 16'h8003,
              16'h800A, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            send(v[i], (i == 5), 0);
        end
        wait_result();
        check_result("f2", 16'h8003, 4'd8, 4'd6, 1'b0, 1'b1);
        ack();

        // Frame 3: SAT at pos4 and pos7, forced close at 10 beats
        v = '{16'h0100, 16'h0200, 16'h0050, 16'h0300, 16'h8000,
              16'h0400, 16'h0010, 16'h8000, 16'h7FFF, 16'h0001};
        for (int i = 0; i < 10; i++) begin
            send(v[i], 1'b0, 0);
        end
        wait_result();
        check_result("f3", 16'h8000, 4'd5, 4'd10, 1'b1, 1'b0);
`ifdef ARGMAX_TOP2_EN
        check("f3_max2",   out_max2,   16'h8000);
        check("f3_index2", out_index2, 4'd2);
`endif
        ack();

        // Frame 4: 13 beats without in_last on the first 10 -> closes at 10
        for (int i = 0; i < 10; i++) begin
            send(DATA_W'(i + 1), 1'b0, 0);
        end
        wait_result();
        check_result("f4a", 16'h000A, 4'd0, 4'd10, 1'b0, 1'b0);
        ack();
        send(16'h0020, 1'b0, 0);
        send(16'h0030, 1'b0, 0);
        send(16'h0025, 1'b1, 0);
        wait_result();
        check_result("f4b", 16'h0030, 4'd8, 4'd3, 1'b0, 1'b1);
`ifdef ARGMAX_TOP2_EN
        check("f4b_max2",   out_max2,   16'h0025);
        check("f4b_index2", out_index2, 4'd7);
`endif
        ack();

        // Frame 5: random input gaps, then DONE held with out_ready low while
        // a beat is already waiting on the input
        v = '{16'h0004, 16'h0011, 16'h8002, 16'h0011, 16'h000F,
              16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            send(v[i], (i == 4), int'($urandom_range(0, 3)));
        end
        wait_result();
        check_result("f5", 16'h0011, 4'd8, 4'd5, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_in_ready",  in_ready,  0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_max",   out_max,   16'h0011);
            check("hold_out_count", out_count, 4'd5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("f6_latency_valid", out_valid, 1);
        check_result("f6", 16'h7FFF, 4'd9, 4'd1, 1'b0, 1'b1);
`ifdef ARGMAX_TOP2_EN
        check("f6_max2",   out_max2,   16'h0000);
        check("f6_index2", out_index2, 4'd0);
`endif
        ack();

        // Frame 7: reset while beat 4 is presented
        send(16'h0050, 1'b0, 0);
        send(16'h0060, 1'b0, 0);
        send(16'h0070, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 16'h0080;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready",  in_ready,  0);
        check("midrst_out_count", out_count, 0);
        check("midrst_out_max",   out_max,   0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(16'h0001, 1'b0, 0);
        send(16'h0002, 1'b1, 0);
        wait_result();
        check_result("f7", 16'h0002, 4'd8, 4'd2, 1'b0, 1'b1);
        ack();

        // Frame 8: runner-up pattern
        send(16'h0005, 1'b0, 0);
        send(16'h0009, 1'b0, 0);
        send(16'h0007, 1'b1, 0);
        wait_result();
        check_result("f8", 16'h0009, 4'd8, 4'd3, 1'b0, 1'b1);
`ifdef ARGMAX_TOP2_EN
        check("f8_max2",   out_max2,   16'h0007);
        check("f8_index2", out_index2, 4'd7);
`endif
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
